// File: rtl/idct_top.sv
// idct_top -- 8x8 two-dimensional inverse DCT.
//
// A row pass turns each accepted coefficient row into one row of a 16-bit
// signed transpose buffer. Once row 7 is accepted, a column pass emits the
// block as 8 pixel rows on 8 consecutive cycles.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  coefficient row handshake (in_ready high only in LOAD)
//   y0..y7             signed IN_W coefficients, y0 = DC / lowest frequency
//   x0..x7             unsigned OUT_W reconstructed pixels
//   out_valid/out_row  pixel row valid and its row index 0..7
//
// Optional feature: define IDCT_LEVEL_SHIFT_EN to add +128 to every pixel
// before the final clamp, for level-shifted (JPEG-style) coefficient streams.

// One lane: column n of the row pass and pixel n of the column pass.
module idct_lane #(
    parameter int N     = 0,
    parameter int IN_W  = 14,
    parameter int OUT_W = 8,
    parameter int MID_W = 16,
    parameter int FRAC  = 8
) (
    input  logic [7:0][IN_W-1:0]  y,     // coefficient row, [k]
    input  logic [7:0][MID_W-1:0] bcol,  // buffer column n, [r]
    input  logic [2:0]            m,     // output row being emitted
    output logic [MID_W-1:0]      b,     // row-pass result for column n
    output logic [OUT_W-1:0]      p      // pixel n of output row m
);
    localparam int CW  = 9;               // cosine constant width
    localparam int RW  = CW + IN_W + 3;   // row-pass accumulator
    localparam int CLW = CW + MID_W + 3;  // column-pass accumulator
    localparam int RND = 1 << (FRAC - 1);
    localparam logic signed [RW-1:0]  BMAX = RW'(2**(MID_W-1) - 1);
    localparam logic signed [RW-1:0]  BMIN = ~BMAX;
    localparam logic signed [CLW-1:0] PMAX = CLW'(2**OUT_W - 1);

    // round(128*cos(i*pi/16)) for i = 0..8
    function automatic logic signed [CW-1:0] cosq(input logic [3:0] i);
        case (i)
            4'd0:    cosq = 9'sd128;
            4'd1:    cosq = 9'sd126;
            4'd2:    cosq = 9'sd118;
            4'd3:    cosq = 9'sd106;
            4'd4:    cosq = 9'sd91;
            4'd5:    cosq = 9'sd71;
            4'd6:    cosq = 9'sd49;
            4'd7:    cosq = 9'sd25;
            default: cosq = 9'sd0;
        endcase
    endfunction

    // C(k,n): fold the angle (2n+1)k*pi/16 into the first quadrant by symmetry.
    function automatic logic signed [CW-1:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] a;
        a = 5'((2 * n + 1) * k);
        if (k == 3'd0)       coef = 9'sd91;
        else if (a <= 5'd8)  coef = cosq(4'(a));
        else if (a <= 5'd16) coef = -cosq(4'(16 - a));
        else if (a <= 5'd24) coef = -cosq(4'(a - 16));
        else                 coef = cosq(4'(32 - a));
    endfunction

    logic signed [RW-1:0]  rs, rsh;
    logic signed [CLW-1:0] cs, csh;

    always_comb begin
        rs = RW'(RND);
        for (int k = 0; k < 8; k++)
            rs = rs + RW'(coef(3'(k), 3'(N))) * RW'($signed(y[k]));
        rsh = rs >>> FRAC;
        if (rsh > BMAX)      b = MID_W'(BMAX);
        else if (rsh < BMIN) b = MID_W'(BMIN);
        else                 b = rsh[MID_W-1:0];
    end

    always_comb begin
        cs = CLW'(RND);
        for (int r = 0; r < 8; r++)
            cs = cs + CLW'(coef(3'(r), m)) * CLW'($signed(bcol[r]));
        csh = cs >>> FRAC;
`ifdef IDCT_LEVEL_SHIFT_EN
        csh = csh + CLW'(128);
`else
`endif
        if (csh[CLW-1])      p = '0;
        else if (csh > PMAX) p = '1;
        else                 p = csh[OUT_W-1:0];
    end
endmodule

module idct_top #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 8,
    parameter int MID_W = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  y0,
    input  logic [IN_W-1:0]  y1,
    input  logic [IN_W-1:0]  y2,
    input  logic [IN_W-1:0]  y3,
    input  logic [IN_W-1:0]  y4,
    input  logic [IN_W-1:0]  y5,
    input  logic [IN_W-1:0]  y6,
    input  logic [IN_W-1:0]  y7,
    output logic [OUT_W-1:0] x0,
    output logic [OUT_W-1:0] x1,
    output logic [OUT_W-1:0] x2,
    output logic [OUT_W-1:0] x3,
    output logic [OUT_W-1:0] x4,
    output logic [OUT_W-1:0] x5,
    output logic [OUT_W-1:0] x6,
    output logic [OUT_W-1:0] x7,
    output logic             out_valid,
    output logic [2:0]       out_row
);
    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

    state_t                       state, state_n;
    logic [2:0]                   cnt, cnt_n;
    logic                         wr, emit;
    logic [7:0][IN_W-1:0]         yv;
    logic [7:0][MID_W-1:0]        brow;    // [n]
    logic [7:0][7:0][MID_W-1:0]   tbuf_q;  // [r][n]
    logic [7:0][7:0][MID_W-1:0]   tbuf_t;  // [n][r]
    logic [7:0][OUT_W-1:0]        pix, x_q;

    assign yv       = {y7, y6, y5, y4, y3, y2, y1, y0};
    assign in_ready = (state == LOAD);
    assign {x7, x6, x5, x4, x3, x2, x1, x0} = x_q;

    always_comb begin
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++)
                tbuf_t[n][r] = tbuf_q[r][n];
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        idct_lane #(
            .N(g), .IN_W(IN_W), .OUT_W(OUT_W), .MID_W(MID_W), .FRAC(FRAC)
        ) u_lane (
            .y(yv), .bcol(tbuf_t[g]), .m(cnt), .b(brow[g]), .p(pix[g])
        );
    end

    // cnt is the buffer row being written in LOAD and the output row in EMIT.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr      = 1'b0;
        emit    = 1'b0;
        case (state)
            LOAD: if (in_valid) begin
                wr    = 1'b1;
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) state_n = EMIT;
            end
            EMIT: begin
                emit  = 1'b1;
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            x_q       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out_valid <= emit;
            if (emit) begin
                out_row <= cnt;
                x_q     <= pix;
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr) tbuf_q[cnt] <= brow;
    end
endmodule

// File: tb/tb_idct_top.sv
module tb_idct_top;
    localparam int IN_W  = 14;
    localparam int OUT_W = 8;
`ifdef IDCT_LEVEL_SHIFT_EN
    localparam bit LS = 1'b1;
`else
    localparam bit LS = 1'b0;
`endif

    typedef logic [7:0][7:0][IN_W-1:0] blk_t;   // [row][k]
    typedef logic [7:0][63:0]          eblk_t;  // [m] packed {x7..x0}
    typedef struct {
        logic [2:0]  row;
        logic [63:0] pix;
        int          cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready, out_valid;
    logic [7:0][IN_W-1:0] yv = '0;
    logic [OUT_W-1:0]     x0, x1, x2, x3, x4, x5, x6, x7;
    logic [2:0]           out_row;

    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;
    exp_t sb[$];

    idct_top dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]),
        .y4(yv[4]), .y5(yv[5]), .y6(yv[6]), .y7(yv[7]),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .out_valid(out_valid), .out_row(out_row)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        asserts++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [63:0] rowv(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic eblk_t same_rows(input logic [63:0] r);
        eblk_t e;
        for (int m = 0; m < 8; m++) e[m] = r;
        return e;
    endfunction

    function automatic eblk_t flat(input int v);
        return same_rows(rowv(v, v, v, v, v, v, v, v));
    endfunction

    function automatic eblk_t per_row(input int a0, a1, a2, a3, a4, a5, a6, a7);
        eblk_t e;
        e[0] = rowv(a0, a0, a0, a0, a0, a0, a0, a0);
        e[1] = rowv(a1, a1, a1, a1, a1, a1, a1, a1);
        e[2] = rowv(a2, a2, a2, a2, a2, a2, a2, a2);
        e[3] = rowv(a3, a3, a3, a3, a3, a3, a3, a3);
        e[4] = rowv(a4, a4, a4, a4, a4, a4, a4, a4);
        e[5] = rowv(a5, a5, a5, a5, a5, a5, a5, a5);
        e[6] = rowv(a6, a6, a6, a6, a6, a6, a6, a6);
        e[7] = rowv(a7, a7, a7, a7, a7, a7, a7, a7);
        return e;
    endfunction

    function automatic blk_t one_coef(input int r, input int k, input int v);
        blk_t b = '0;
        b[r][k] = IN_W'(v);
        return b;
    endfunction

    // Drives one block; expectations are queued when row 7 is accepted.
    task automatic send_block(input blk_t b, input eblk_t e, input bit toggle,
                              input bit hold, output int last);
        int k = 0;
        int it = 0;
        last = -1;
        while (k < 8 && it < 200) begin
            @(negedge clk);
            in_valid = toggle ? (it % 2 == 0) : 1'b1;
            yv = b[k];
            if (in_valid && in_ready) begin
                k++;
                if (k == 8) begin
                    last = cyc;
                    for (int m = 0; m < 8; m++)
                        sb.push_back('{row: 3'(m), pix: e[m], cyc: cyc + 2 + m});
                end
            end
            it++;
        end
        if (k < 8) begin
            asserts++;
            fails++;
            $display("FAIL send_timeout: got %0d rows accepted expected 8", k);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        logic [63:0] xv;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                xv = {x7, x6, x5, x4, x3, x2, x1, x0};
                if (sb.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL spurious_out: got row %0d expected no output", out_row);
                end else begin
                    e = sb.pop_front();
                    chk("out_row", 64'(out_row), 64'(e.row));
                    chk("pixels", xv, e.pix);
                    chk("out_cycle", 64'(cyc), 64'(e.cyc));
                    chk("in_ready_emit", 64'(in_ready), 64'(out_row == 3'd7));
                end
            end
        end
    endtask

    initial begin
        int    la, lb, n;
        eblk_t e5, e6;
        fork
            monitor();
        join_none

        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_x", {x7, x6, x5, x4, x3, x2, x1, x0}, 64'd0);
        #10 rst = 1'b0;

        e5 = same_rows(LS ? rowv(173, 166, 153, 137, 119, 103, 90, 83)
                          : rowv(45, 38, 25, 9, 0, 0, 0, 0));
        e6 = LS ? per_row(255, 255, 229, 164, 92, 27, 0, 0)
                : per_row(179, 151, 101, 36, 0, 0, 0, 0);

        send_block('0, flat(LS ? 128 : 0), 1'b0, 1'b0, la);
        send_block(one_coef(0, 0, 1024), flat(LS ? 255 : 129), 1'b1, 1'b0, la);
        // Two blocks with in_valid held high through EMIT.
        send_block(one_coef(0, 0, 2040), flat(255), 1'b0, 1'b1, la);
        send_block(one_coef(0, 0, -800), flat(LS ? 27 : 0), 1'b0, 1'b0, lb);
        chk("held_block_spacing", 64'(lb - la), 64'd16);
        send_block(one_coef(0, 1, 256), e5, 1'b0, 1'b0, la);
        send_block(one_coef(1, 0, 1024), e6, 1'b0, 1'b0, la);

        // Reset asserted while output row 3 is on the bus.
        send_block(one_coef(1, 0, 1024), e6, 1'b0, 1'b0, la);
        n = 0;
        while (!(out_valid && out_row == 3'd3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_row3", 64'(n < 50), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_x", {x7, x6, x5, x4, x3, x2, x1, x0}, 64'd0);
        sb.delete();
        #1 rst = 1'b0;
        send_block(one_coef(0, 1, 256), e5, 1'b0, 1'b0, la);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            asserts++;
            fails++;
            $display("FAIL drain_timeout: got %0d rows pending expected 0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
